// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection for a 5-stage in-order core.
// Tracks the destination of the instructions ahead of ID in three small
// shadow stages (EX, MEM, WB), derives per-operand forwarding selects,
// detects load-use hazards that need a one-cycle stall, resolves the
// interaction with taken branches, and counts load-use stall cycles.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             re1_ID,
  input  logic             re2_ID,
  input  logic [4:0]       rd_ID,
  input  logic             we_ID,
  input  logic [1:0]       wsel_ID,
  input  logic             br_taken_EX,
  output logic             RAW_A_rR1,
  output logic             RAW_A_rR2,
  output logic             RAW_B_rR1,
  output logic             RAW_B_rR2,
  output logic             RAW_C_rR1,
  output logic             RAW_C_rR2,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic [CNT_W-1:0] stall_cnt
);

  // Write-back source encoding of the ID instruction.
  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_DRAM = 2'd1,
    WSEL_PC4  = 2'd2,
    WSEL_IMM  = 2'd3
  } wsel_e;

  // What a downstream stage needs to remember about its instruction.
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } stage_t;

  localparam stage_t BUBBLE = '{rd: 5'd0, we: 1'b0, is_load: 1'b0};

  stage_t           ex_q, ex_d;
  stage_t           mem_q, mem_d;
  stage_t           wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A stage supplies operand k only if it really writes, targets the same
  // non-zero register, and ID actually reads that operand.
  function automatic logic stage_match(input stage_t s, input logic [4:0] rs,
                                       input logic re);
    return s.we && (s.rd == rs) && (rs != 5'd0) && re;
  endfunction

  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic load_use;
  logic raw_a1, raw_a2, raw_b1, raw_b2, raw_c1, raw_c2;

  // Per-stage operand matches and the load-use condition.
  always_comb begin
    ex_m1    = stage_match(ex_q,  rs1_ID, re1_ID);
    ex_m2    = stage_match(ex_q,  rs2_ID, re2_ID);
    mem_m1   = stage_match(mem_q, rs1_ID, re1_ID);
    mem_m2   = stage_match(mem_q, rs2_ID, re2_ID);
    wb_m1    = stage_match(wb_q,  rs1_ID, re1_ID);
    wb_m2    = stage_match(wb_q,  rs2_ID, re2_ID);
    load_use = (ex_m1 || ex_m2) && ex_q.is_load;
  end

  // Forwarding selects: youngest producer wins, and nothing is forwarded
  // while a load-use stall is pending because ID is re-evaluated next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    raw_a1 = 1'b0;
    raw_a2 = 1'b0;
    raw_b1 = 1'b0;
    raw_b2 = 1'b0;
    raw_c1 = 1'b0;
    raw_c2 = 1'b0;
    if (!load_use) begin
      if (ex_m1)       raw_a1 = 1'b1;
      else if (mem_m1) raw_b1 = 1'b1;
      else if (wb_m1)  raw_c1 = 1'b1;
      if (ex_m2)       raw_a2 = 1'b1;
      else if (mem_m2) raw_b2 = 1'b1;
      else if (wb_m2)  raw_c2 = 1'b1;
    end
  end

  assign RAW_A_rR1 = raw_a1;
  assign RAW_A_rR2 = raw_a2;
  assign RAW_B_rR1 = raw_b1;
  assign RAW_B_rR2 = raw_b2;
  assign RAW_C_rR1 = raw_c1;
  assign RAW_C_rR2 = raw_c2;

  // Pipeline control: a taken branch kills the stall (the stalled
  // instruction is on the wrong path) and flushes both front registers.
  // The shadow stages are bubbles in reset, so only the branch input needs
  // masking to keep every control output quiet while reset is held.
  always_comb begin
    stall_PC    = load_use && !br_taken_EX && cpu_rst_n;
    stall_IF_ID = stall_PC;
    flush_ID_EX = (load_use || br_taken_EX) && cpu_rst_n;
    flush_IF_ID = br_taken_EX && cpu_rst_n;
  end

  // Next shadow state: shift down the pipe, inserting a bubble into EX
  // whenever ID/EX is flushed. Writes to x0 are dropped at entry.
  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = BUBBLE;
    if (!flush_ID_EX) begin
      ex_d.rd      = rd_ID;
      ex_d.we      = we_ID && (rd_ID != 5'd0);
      ex_d.is_load = (wsel_e'(wsel_ID) == WSEL_DRAM);
    end
  end

  // Saturating count of load-use stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_PC && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;

  // State registers with asynchronous clear to bubbles and a zero count.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (!cpu_rst_n) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
